// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the EX->MEM request path.
// Holds the access-size encoding, op-field widths, the layout of the
// per-request info entry handed to the MEM stage, and the alignment helper.
// Info entry layout (MSB..LSB): {tag[TAG_W], off[OFF_W], info_hdr_t}.
package lsu_pkg;

  localparam int SIZE_W = 2;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  // Fixed-width part of an info entry; tag and byte offset are appended by
  // the user because their widths depend on module parameters.
  typedef struct packed {
    logic      wr;
    lsu_size_e size;
    logic      sgn;
    logic      ale;
  } info_hdr_t;

  localparam int INFO_HDR_W = $bits(info_hdr_t);

  // True when the low address bits are not a multiple of the access size.
  function automatic logic misaligned(input lsu_size_e size, input logic [2:0] addr_lo);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = |addr_lo[1:0];
      SZ_D:    mis = |addr_lo[2:0];
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_info_fifo.sv
// lsu_info_fifo: small FIFO of outstanding-request info entries.
// Each entry carries a WIDTH-bit payload plus a separate cancel bit so that a
// pipeline flush can mark every stored entry cancelled in one cycle.
// Ports:
//   clk, resetn             clock, async active-low reset
//   push, push_data,        write an entry (ignored when full)
//   push_cancel             cancel bit of the written entry
//   pop                     drop the head entry (ignored when empty)
//   cancel_all              set the cancel bit of every stored entry
//   head_data, head_cancel  head entry
//   full, empty, count      occupancy
module lsu_info_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_cancel,
  input  logic             pop,
  input  logic             cancel_all,
  output logic [WIDTH-1:0] head_data,
  output logic             head_cancel,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] cancel_r;
  logic [DEPTH-1:0] cancel_nxt_s;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointer increment that wraps modulo DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(DEPTH - 1)) begin
      n = {PTR_W{1'b0}};
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  assign full        = (count_r == CNT_W'(DEPTH));
  assign empty       = (count_r == {CNT_W{1'b0}});
  assign count       = count_r;
  assign head_data   = mem_r[rd_ptr_r];
  assign head_cancel = cancel_r[rd_ptr_r];
  assign do_push_s   = push && !full;
  assign do_pop_s    = pop && !empty;

  // Next cancel vector: a flush marks everything, a new entry gets its own bit.
  always_comb begin
    cancel_nxt_s = cancel_r;
    if (cancel_all) begin
      cancel_nxt_s = {DEPTH{1'b1}};
    end else begin
      cancel_nxt_s = cancel_r;
    end
    if (do_push_s) begin
      cancel_nxt_s[wr_ptr_r] = push_cancel || cancel_all;
    end else begin
      cancel_nxt_s[wr_ptr_r] = cancel_nxt_s[wr_ptr_r];
    end
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      cancel_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      cancel_r <= cancel_nxt_s;
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_req.sv
// ex_mem_req: turns an EX-stage memory op into an SRAM-like request and
// records an info entry per op (in program order) for the MEM stage.
// Misaligned ops issue no request and are recorded with info_ale set.
// Ports:
//   clk, resetn                            clock, async active-low reset
//   in_valid/in_ready, in_wr, in_size,     EX-side op handshake and fields
//   in_signed, in_addr, in_wdata, in_tag
//   flush                                  cancel everything in flight
//   req, req_wr, req_size, req_addr,       memory request, held until addr_ok
//   req_wstrb, req_wdata, addr_ok
//   info_valid/info_ready, info_*          head of the info FIFO
module ex_mem_req
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 5,
  localparam int STRB_W = DATA_W / 8,
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wr,
  input  logic [SIZE_W-1:0] in_size,
  input  logic              in_signed,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              req,
  output logic              req_wr,
  output logic [SIZE_W-1:0] req_size,
  output logic [ADDR_W-1:0] req_addr,
  output logic [STRB_W-1:0] req_wstrb,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              addr_ok,
  output logic              info_valid,
  input  logic              info_ready,
  output logic              info_wr,
  output logic [SIZE_W-1:0] info_size,
  output logic              info_signed,
  output logic [OFF_W-1:0]  info_off,
  output logic [TAG_W-1:0]  info_tag,
  output logic              info_ale,
  output logic              info_cancel
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int FIFO_W = TAG_W + OFF_W + INFO_HDR_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [0:0]        state_r;
  logic              req_r;
  logic              req_wr_r;
  logic [SIZE_W-1:0] req_size_r;
  logic [ADDR_W-1:0] req_addr_r;
  logic [STRB_W-1:0] req_wstrb_r;
  logic [DATA_W-1:0] req_wdata_r;
  logic              req_signed_r;
  logic [TAG_W-1:0]  req_tag_r;
  logic              cancel_pend_r;

  logic              in_ready_s;
  logic              accept_s;
  logic              mis_s;
  logic [STRB_W-1:0] lane_ones_s;
  logic [STRB_W-1:0] wstrb_s;
  logic [DATA_W-1:0] wdata_s;
  logic              push_s;
  logic              push_cancel_s;
  info_hdr_t         push_hdr_s;
  logic [OFF_W-1:0]  push_off_s;
  logic [TAG_W-1:0]  push_tag_s;
  logic [FIFO_W-1:0] push_data_s;
  logic              pop_s;
  logic [FIFO_W-1:0] head_data_s;
  info_hdr_t         head_hdr_s;
  logic              head_cancel_s;
  logic              full_s;
  logic              empty_s;
  logic [CNT_W-1:0]  count_s;

  assign in_ready_s = (state_r == ST_IDLE) && (count_s < CNT_W'(DEPTH)) && !flush;
  assign accept_s   = in_valid && in_ready_s;
  // A doubleword cannot be carried on a 32-bit bus, so it is treated as misaligned.
  assign mis_s      = misaligned(lsu_size_e'(in_size), in_addr[2:0]) ||
                      ((DATA_W == 32) && (in_size == 2'd3));

  // Byte strobes and lane replication of the store data.
  always_comb begin
    lane_ones_s = {STRB_W{1'b0}};
    wdata_s     = {DATA_W{1'b0}};
    for (int i = 0; i < STRB_W; i++) begin
      lane_ones_s[i]     = (i < (32'sd1 << in_size));
      wdata_s[8*i +: 8]  = in_wdata[8*(i % (32'sd1 << in_size)) +: 8];
    end
    if (in_wr) begin
      wstrb_s = lane_ones_s << in_addr[OFF_W-1:0];
    end else begin
      wstrb_s = {STRB_W{1'b0}};
    end
  end

  // Info entry source: the held request when completing, else the incoming misaligned op.
  always_comb begin
    push_hdr_s = '0;
    push_off_s = {OFF_W{1'b0}};
    push_tag_s = {TAG_W{1'b0}};
    if (state_r == ST_REQ) begin
      push_hdr_s.wr   = req_wr_r;
      push_hdr_s.size = lsu_size_e'(req_size_r);
      push_hdr_s.sgn  = req_signed_r;
      push_hdr_s.ale  = 1'b0;
      push_off_s      = req_addr_r[OFF_W-1:0];
      push_tag_s      = req_tag_r;
    end else begin
      push_hdr_s.wr   = in_wr;
      push_hdr_s.size = lsu_size_e'(in_size);
      push_hdr_s.sgn  = in_signed;
      push_hdr_s.ale  = 1'b1;
      push_off_s      = in_addr[OFF_W-1:0];
      push_tag_s      = in_tag;
    end
  end

  assign push_s        = ((accept_s && mis_s) || ((state_r == ST_REQ) && addr_ok)) && !full_s;
  // A request already on the bus cannot be withdrawn; its entry inherits the flush.
  assign push_cancel_s = flush || ((state_r == ST_REQ) && cancel_pend_r);
  assign push_data_s   = {push_tag_s, push_off_s, push_hdr_s};
  assign pop_s         = !empty_s && info_ready;

  lsu_info_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_info_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push        (push_s),
    .push_data   (push_data_s),
    .push_cancel (push_cancel_s),
    .pop         (pop_s),
    .cancel_all  (flush),
    .head_data   (head_data_s),
    .head_cancel (head_cancel_s),
    .full        (full_s),
    .empty       (empty_s),
    .count       (count_s)
  );

  // Request FSM: latch an aligned op, hold it until the memory takes it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= ST_IDLE;
      req_r         <= 1'b0;
      req_wr_r      <= 1'b0;
      req_size_r    <= 2'd0;
      req_addr_r    <= 32'd0;
      req_wstrb_r   <= {STRB_W{1'b0}};
      req_wdata_r   <= {DATA_W{1'b0}};
      req_signed_r  <= 1'b0;
      req_tag_r     <= {TAG_W{1'b0}};
      cancel_pend_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && !mis_s) begin
            state_r       <= ST_REQ;
            req_r         <= 1'b1;
            req_wr_r      <= in_wr;
            req_size_r    <= in_size;
            req_addr_r    <= in_addr;
            req_wstrb_r   <= wstrb_s;
            req_wdata_r   <= wdata_s;
            req_signed_r  <= in_signed;
            req_tag_r     <= in_tag;
            cancel_pend_r <= 1'b0;
          end
        end
        ST_REQ: begin
          if (addr_ok) begin
            state_r       <= ST_IDLE;
            req_r         <= 1'b0;
            cancel_pend_r <= 1'b0;
          end else if (flush) begin
            cancel_pend_r <= 1'b1;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          req_r         <= 1'b0;
          cancel_pend_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_s;
  assign req         = req_r;
  assign req_wr      = req_wr_r;
  assign req_size    = req_size_r;
  assign req_addr    = req_addr_r;
  assign req_wstrb   = req_wstrb_r;
  assign req_wdata   = req_wdata_r;

  assign head_hdr_s  = head_data_s[INFO_HDR_W-1:0];
  assign info_valid  = !empty_s;
  assign info_wr     = head_hdr_s.wr;
  assign info_size   = head_hdr_s.size;
  assign info_signed = head_hdr_s.sgn;
  assign info_ale    = head_hdr_s.ale;
  assign info_off    = head_data_s[INFO_HDR_W +: OFF_W];
  assign info_tag    = head_data_s[INFO_HDR_W + OFF_W +: TAG_W];
  // An entry popped in the same cycle as a flush is presented as cancelled.
  assign info_cancel = (head_cancel_s || flush) && !empty_s;

endmodule

// File: tb/tb_ex_mem_req.sv
// Directed bench for ex_mem_req: one 32-bit and one 64-bit instance share
// the op fields; each has its own in_valid so only one is active at a time.
module tb_ex_mem_req;

  logic        clk = 1'b0;
  logic        resetn;
  logic        v32, v64;
  logic        in_wr, in_signed;
  logic [1:0]  in_size;
  logic [31:0] in_addr;
  logic [63:0] in_wdata;
  logic [4:0]  in_tag;
  logic        flush, addr_ok, info_ready;

  logic        a_in_ready, a_req, a_req_wr, a_iv, a_iwr, a_isig, a_iale, a_icancel;
  logic [1:0]  a_req_size, a_isize, a_ioff;
  logic [31:0] a_req_addr, a_wdata;
  logic [3:0]  a_wstrb;
  logic [4:0]  a_itag;

  logic        b_in_ready, b_req, b_req_wr, b_iv, b_iwr, b_isig, b_iale, b_icancel;
  logic [1:0]  b_req_size, b_isize;
  logic [2:0]  b_ioff;
  logic [31:0] b_req_addr;
  logic [63:0] b_wdata;
  logic [7:0]  b_wstrb;
  logic [4:0]  b_itag;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_mem_req #(.DATA_W(32), .DEPTH(2), .TAG_W(5)) dut32 (
    .clk(clk), .resetn(resetn), .in_valid(v32), .in_ready(a_in_ready),
    .in_wr(in_wr), .in_size(in_size), .in_signed(in_signed), .in_addr(in_addr),
    .in_wdata(in_wdata[31:0]), .in_tag(in_tag), .flush(flush),
    .req(a_req), .req_wr(a_req_wr), .req_size(a_req_size), .req_addr(a_req_addr),
    .req_wstrb(a_wstrb), .req_wdata(a_wdata), .addr_ok(addr_ok),
    .info_valid(a_iv), .info_ready(info_ready), .info_wr(a_iwr), .info_size(a_isize),
    .info_signed(a_isig), .info_off(a_ioff), .info_tag(a_itag), .info_ale(a_iale),
    .info_cancel(a_icancel)
  );

  ex_mem_req #(.DATA_W(64), .DEPTH(2), .TAG_W(5)) dut64 (
    .clk(clk), .resetn(resetn), .in_valid(v64), .in_ready(b_in_ready),
    .in_wr(in_wr), .in_size(in_size), .in_signed(in_signed), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_tag(in_tag), .flush(flush),
    .req(b_req), .req_wr(b_req_wr), .req_size(b_req_size), .req_addr(b_req_addr),
    .req_wstrb(b_wstrb), .req_wdata(b_wdata), .addr_ok(addr_ok),
    .info_valid(b_iv), .info_ready(info_ready), .info_wr(b_iwr), .info_size(b_isize),
    .info_signed(b_isig), .info_off(b_ioff), .info_tag(b_itag), .info_ale(b_iale),
    .info_cancel(b_icancel)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; v32 = 1'b0; v64 = 1'b0; in_wr = 1'b0; in_size = 2'd0;
    in_signed = 1'b0; in_addr = 32'd0; in_wdata = 64'd0; in_tag = 5'd0;
    flush = 1'b0; addr_ok = 1'b0; info_ready = 1'b0;
    step(); step();
    check("rst_req", a_req, 1'b0);
    check("rst_info_valid", a_iv, 1'b0);
    check("rst_wstrb", a_wstrb, 4'h0);
    check("rst_req64", b_req, 1'b0);
    resetn = 1'b1;
    step();
    check("rst_in_ready", a_in_ready, 1'b1);
    check("rst_in_ready64", b_in_ready, 1'b1);

    // Store halfword at 0x1002, addr_ok on the third request cycle
    v32 = 1'b1; in_wr = 1'b1; in_size = 2'd1; in_addr = 32'h1002;
    in_wdata = 64'hABCD; in_tag = 5'd3;
    step(); v32 = 1'b0;
    check("sh_req", a_req, 1'b1);
    check("sh_wstrb", a_wstrb, 4'hC);
    check("sh_wdata", a_wdata, 32'hABCDABCD);
    check("sh_addr", a_req_addr, 32'h1002);
    check("sh_size", a_req_size, 2'd1);
    check("sh_busy", a_in_ready, 1'b0);
    step();
    check("sh_hold2", a_req, 1'b1);
    check("sh_hold2_wstrb", a_wstrb, 4'hC);
    step();
    check("sh_hold3", a_req, 1'b1);
    addr_ok = 1'b1;
    step(); addr_ok = 1'b0;
    check("sh_req_drop", a_req, 1'b0);
    check("sh_iv", a_iv, 1'b1);
    check("sh_off", a_ioff, 2'd2);
    check("sh_iwr", a_iwr, 1'b1);
    check("sh_tag", a_itag, 5'd3);
    check("sh_ale", a_iale, 1'b0);
    check("sh_cancel", a_icancel, 1'b0);
    check("sh_ready", a_in_ready, 1'b1);
    info_ready = 1'b1; step(); info_ready = 1'b0;
    check("sh_popped", a_iv, 1'b0);

    // Misaligned load word at 0x1001
    in_wr = 1'b0; in_size = 2'd2; in_addr = 32'h1001; in_tag = 5'd7; in_signed = 1'b1;
    v32 = 1'b1;
    check("lw_mis_ready_pre", a_in_ready, 1'b1);
    step(); v32 = 1'b0;
    check("lw_mis_noreq", a_req, 1'b0);
    check("lw_mis_iv", a_iv, 1'b1);
    check("lw_mis_ale", a_iale, 1'b1);
    check("lw_mis_tag", a_itag, 5'd7);
    check("lw_mis_sig", a_isig, 1'b1);
    check("lw_mis_off", a_ioff, 2'd1);
    check("lw_mis_ready", a_in_ready, 1'b1);
    info_ready = 1'b1; step(); info_ready = 1'b0;

    // Two aligned loads fill the FIFO
    in_signed = 1'b0; in_addr = 32'h1000; in_tag = 5'd1; v32 = 1'b1;
    step(); v32 = 1'b0;
    check("ld1_req", a_req, 1'b1);
    check("ld1_wstrb", a_wstrb, 4'h0);
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    in_addr = 32'h1004; in_tag = 5'd2; v32 = 1'b1;
    step(); v32 = 1'b0;
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    check("full_in_ready", a_in_ready, 1'b0);
    check("full_iv", a_iv, 1'b1);
    check("full_head_tag", a_itag, 5'd1);
    info_ready = 1'b1; step(); info_ready = 1'b0;
    check("pop_in_ready", a_in_ready, 1'b1);
    check("pop_head_tag", a_itag, 5'd2);

    // Flush while a request is outstanding with one stored entry
    in_addr = 32'h1008; in_tag = 5'd9; v32 = 1'b1;
    step(); v32 = 1'b0;
    check("fl_req", a_req, 1'b1);
    flush = 1'b1; step(); flush = 1'b0;
    check("fl_req_kept", a_req, 1'b1);
    check("fl_head_cancel", a_icancel, 1'b1);
    check("fl_head_tag", a_itag, 5'd2);
    step();
    check("fl_req_kept2", a_req, 1'b1);
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    check("fl_req_drop", a_req, 1'b0);
    check("fl_head_tag_after", a_itag, 5'd2);
    check("fl_head_cancel_after", a_icancel, 1'b1);
    info_ready = 1'b1; step();
    check("fl_second_tag", a_itag, 5'd9);
    check("fl_second_cancel", a_icancel, 1'b1);
    check("fl_second_ale", a_iale, 1'b0);
    step(); info_ready = 1'b0;
    check("fl_drained", a_iv, 1'b0);

    // Flush coincident with an offered op blocks the accept
    in_addr = 32'h100C; in_tag = 5'd4; v32 = 1'b1; flush = 1'b1;
    #1;
    check("fl_accept_ready", a_in_ready, 1'b0);
    step(); v32 = 1'b0; flush = 1'b0;
    check("fl_accept_noreq", a_req, 1'b0);
    check("fl_accept_noentry", a_iv, 1'b0);

    // Flush coincident with a pop
    in_addr = 32'h1003; in_tag = 5'd10; v32 = 1'b1;
    step(); in_tag = 5'd11;
    step(); v32 = 1'b0;
    check("flpop_pre_cancel", a_icancel, 1'b0);
    info_ready = 1'b1; flush = 1'b1;
    #1;
    check("flpop_head_cancel", a_icancel, 1'b1);
    check("flpop_head_tag", a_itag, 5'd10);
    step(); info_ready = 1'b0; flush = 1'b0;
    check("flpop_rest_tag", a_itag, 5'd11);
    check("flpop_rest_cancel", a_icancel, 1'b1);
    info_ready = 1'b1; step(); info_ready = 1'b0;
    check("flpop_drained", a_iv, 1'b0);

    // Doubleword on the 32-bit instance is misaligned
    in_wr = 1'b1; in_size = 2'd3; in_addr = 32'h2000; in_tag = 5'd4; v32 = 1'b1;
    step(); v32 = 1'b0;
    check("d32_noreq", a_req, 1'b0);
    check("d32_ale", a_iale, 1'b1);
    check("d32_size", a_isize, 2'd3);
    info_ready = 1'b1; step(); info_ready = 1'b0;

    // 64-bit instance: store doubleword and store byte
    in_wdata = 64'h1122334455667788; in_tag = 5'd5; v64 = 1'b1;
    step(); v64 = 1'b0;
    check("sd64_req", b_req, 1'b1);
    check("sd64_wstrb", b_wstrb, 8'hFF);
    check("sd64_wdata", b_wdata, 64'h1122334455667788);
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    check("sd64_iv", b_iv, 1'b1);
    check("sd64_off", b_ioff, 3'd0);
    check("sd64_ale", b_iale, 1'b0);
    info_ready = 1'b1; step(); info_ready = 1'b0;
    in_size = 2'd0; in_addr = 32'h2005; in_wdata = 64'h5A; v64 = 1'b1;
    step(); v64 = 1'b0;
    check("sb64_wstrb", b_wstrb, 8'h20);
    check("sb64_wdata", b_wdata, 64'h5A5A5A5A5A5A5A5A);
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    check("sb64_off", b_ioff, 3'd5);
    check("sb64_tag", b_itag, 5'd5);
    info_ready = 1'b1; step(); info_ready = 1'b0;
    check("sb64_drained", b_iv, 1'b0);

    // Reset while a request is outstanding and an entry is stored
    in_wr = 1'b0; in_size = 2'd2; in_addr = 32'h3001; in_tag = 5'd6; v32 = 1'b1;
    step(); in_addr = 32'h3000;
    step(); v32 = 1'b0;
    check("rmid_req", a_req, 1'b1);
    check("rmid_iv", a_iv, 1'b1);
    #2; resetn = 1'b0; #1;
    check("rmid_req_async", a_req, 1'b0);
    check("rmid_fifo_empty", a_iv, 1'b0);
    step(); resetn = 1'b1;
    step();
    check("rmid_in_ready", a_in_ready, 1'b1);
    check("rmid_req_after", a_req, 1'b0);
    check("rmid_iv_after", a_iv, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
